// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default widths and the layout of the
// side-effect control field carried alongside each beat.
package pipe_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  localparam int CTRL_RF_WE     = 0;
  localparam int CTRL_RF_RE     = 1;
  localparam int CTRL_DRAM_WE   = 2;
  localparam int CTRL_WB_SEL_LO = 3;
  localparam int CTRL_WB_SEL_HI = 4;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  // Stage instances build their control field through this so bit positions live in one place.
  function automatic logic [DEF_CTRL_W-1:0] pack_ctrl(input logic rf_we, input logic rf_re,
                                                      input logic dram_we, input wb_sel_e wb_sel);
    logic [DEF_CTRL_W-1:0] c;
    c = {DEF_CTRL_W{1'b0}};
    c[CTRL_RF_WE]                     = rf_we;
    c[CTRL_RF_RE]                     = rf_re;
    c[CTRL_DRAM_WE]                   = dram_we;
    c[CTRL_WB_SEL_HI:CTRL_WB_SEL_LO]  = wb_sel;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready beat channel (control + payload) between pipeline stages.
interface pipe_skid_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count requested cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer so upstream ready is a
// flop output; supports flush (bubble insertion) and a stall-cycle counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W,
  parameter int CTRL_W = pipe_pkg::DEF_CTRL_W,
  parameter int CNT_W  = pipe_pkg::DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  pipe_skid_reg_if.slave    up,
  pipe_skid_reg_if.master   dn,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic              r_s_valid;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;

  logic w_in_fire;
  logic w_out_fire;
  logic w_stall;

  assign up.ready   = ~r_s_valid;
  assign w_in_fire  = up.valid & ~r_s_valid;
  assign w_out_fire = r_m_valid & dn.ready;
  assign w_stall    = r_m_valid & ~dn.ready;

  // Main/skid slot update; the skid entry always refills main before any newer input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_ctrl  <= {CTRL_W{1'b0}};
      r_m_data  <= {DATA_W{1'b0}};
      r_s_valid <= 1'b0;
      r_s_ctrl  <= {CTRL_W{1'b0}};
      r_s_data  <= {DATA_W{1'b0}};
    end else if (i_flush) begin
      // Payload is left stale; clearing ctrl is what makes a killed beat harmless.
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_ctrl  <= {CTRL_W{1'b0}};
      r_s_ctrl  <= {CTRL_W{1'b0}};
    end else if (w_out_fire || !r_m_valid) begin
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_ctrl  <= r_s_ctrl;
        r_m_data  <= r_s_data;
        r_s_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_m_valid <= 1'b1;
        r_m_ctrl  <= up.ctrl;
        r_m_data  <= up.data;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_s_valid <= 1'b1;
      r_s_ctrl  <= up.ctrl;
      r_s_data  <= up.data;
    end else begin
      r_s_valid <= r_s_valid;
    end
  end

  // Downstream view of the main slot, with ctrl masked whenever the slot is empty.
  always_comb begin
    dn.valid = r_m_valid;
    dn.data  = r_m_data;
    if (r_m_valid) begin
      dn.ctrl = r_m_ctrl;
    end else begin
      dn.ctrl = {CTRL_W{1'b0}};
    end
  end

  assign o_occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (o_stall_cnt)
  );

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register that replaces the fixed per-field stage registers between pipeline stages (e.g. EXE→MEM). It carries a generic data payload plus a control field with side effects (rf_we, dram_we, wb_sel, ...) under valid/ready flow control. A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path. Adds flush (bubble insertion) and a saturating back-pressure counter.

Parameters:
DATA_W, 96, payload width (e.g. alu_result + pc + store data), never cleared except by reset
CTRL_W, 8, side-effect control bits, forced to 0 whenever the slot is invalid
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  kill all held and incoming entries this cycle
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept; registered, equals NOT skid_valid
in_ctrl  in  CTRL_W  upstream control bits
in_data  in  DATA_W  upstream payload
out_valid  out  1  main slot holds a live beat
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  main-slot control; 0 when out_valid=0
out_data  out  DATA_W  main-slot payload
occupancy  out  2  number of live entries, 0..2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main slot (m_valid, m_ctrl, m_data) drives outputs; skid slot (s_valid, s_ctrl, s_data) is internal.
- Reset (rst=1, async): m_valid=s_valid=0, all ctrl/data regs=0, stall_cnt=0, so out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0. Reset mid-transfer drops every beat.
- Accept: in_fire = in_valid & in_ready. Emit: out_fire = m_valid & out_ready.
- Latency: 1 cycle from in_fire to out_valid when the main slot is empty or draining.
- Per cycle with flush=0:
  - out_fire or !m_valid: main loads from skid if s_valid (skid clears), else from input if in_fire, else m_valid←0.
  - else (main stalled): an in_fire beat goes to skid, s_valid←1.
- Ordering: strict FIFO; the skid entry always leaves before any newer input.
- Full: s_valid=1 ⇒ in_ready=0 next cycle. in_valid while in_ready=0 is not consumed; upstream must hold the beat stable.
- Flush=1 (priority over everything except rst): m_valid←0, s_valid←0, m_ctrl←0, s_ctrl←0. An input beat present that cycle is consumed if in_ready=1 and discarded. out_fire in the same cycle still counts as delivered downstream. Data regs are left as-is.
- out_ctrl = m_valid ? m_ctrl : 0. This is combinational masking, a guarantee in addition to the flush clearing.
- occupancy = m_valid + s_valid.
- Invariant: s_valid=1 implies m_valid=1.
- stall_cnt increments when m_valid & !out_ready, holds at 2^CNT_W−1, and is cleared only by rst. Flush does not clear it.

Decomposition:
- Shared package pipe_pkg: default widths DATA_W/CTRL_W/CNT_W; control-bit index constants (CTRL_RF_WE=0, CTRL_RF_RE=1, CTRL_DRAM_WE=2, CTRL_WB_SEL=4:3).
- Stage instances pack their fields into ctrl/data using these constants.
- Optional sub-module sat_counter (CNT_W, inc, out) for stall_cnt. All other logic stays flat in pipe_skid_reg.

Test Plan:
- Reset: assert rst mid-stream with occupancy=2 → same cycle out_valid=0, out_ctrl=0, in_ready=1 after the next edge, stall_cnt=0.
- Streaming: out_ready=1, beats data=1..5 back-to-back with ctrl=8'h05 → out_data 1..5 on consecutive cycles, 1-cycle latency, in_ready constantly 1, stall_cnt=0.
- Back-pressure: out_ready=0, send A,B,C →
  - A in main, B in skid, occupancy=2, in_ready=0, C held.
  - Release out_ready → outputs A,B,C in order.
  - stall_cnt equals the stalled-cycle count.
- Flush while full: occupancy=2 with ctrl=8'hFF, pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, incoming beat never appears.
- Flush with out_fire: main valid and out_ready=1 with flush=1 → beat counted as delivered that cycle, nothing after.
- Saturation: CNT_W=4, hold out_ready=0 for 20 cycles with m_valid=1 → stall_cnt stops at 15.
